// File: rtl/fifo_stim_gen.sv
// rtl/fifo_stim_gen.sv - phased enqueue/dequeue stimulus generator for a synchronous FIFO under test
// Runs FILL, DRAIN, pseudo-random MIXED and FLUSH phases, never requesting past full or empty.
module fifo_stim_gen #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned QUEUE_DEPTH = 16,
    parameter int unsigned NUM_TXN     = 256,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_full,
    input  logic                  is_empty,
    output logic                  enqueue,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  dequeue,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           enq_count,
    output logic [15:0]           deq_count
);
    localparam int unsigned      TXN_W     = $clog2(NUM_TXN + 1);
    localparam logic [TXN_W-1:0] TXN_LAST  = TXN_W'(NUM_TXN - 1);
    localparam logic [15:0]      LFSR_MASK = 16'hB400;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_MIXED = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    if (DATA_WIDTH == 0 || (DATA_WIDTH % 16) != 0) begin : g_bad_width
        $error("fifo_stim_gen: DATA_WIDTH must be a nonzero multiple of 16");
    end
    if (QUEUE_DEPTH == 0 || NUM_TXN == 0 || SEED == 16'h0000) begin : g_bad_cfg
        $error("fifo_stim_gen: QUEUE_DEPTH and NUM_TXN must be >= 1 and SEED nonzero");
    end

    logic [2:0]       state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [TXN_W-1:0] txn_q, txn_d;
    logic [15:0]      enq_cnt_q, enq_cnt_d;
    logic [15:0]      deq_cnt_q, deq_cnt_d;

    // Requests are combinational on the flags so a flag change blocks the request in the same cycle.
    always_comb begin
        enqueue = 1'b0;
        dequeue = 1'b0;
        case (state_q)
            ST_FILL:  enqueue = ~is_full;
            ST_DRAIN: dequeue = ~is_empty;
            ST_MIXED: begin
                enqueue = lfsr_q[0] & ~is_full;
                dequeue = lfsr_q[1] & ~is_empty;
            end
            ST_FLUSH: dequeue = ~is_empty;
            default: ;
        endcase
    end

    assign busy      = (state_q == ST_FILL) || (state_q == ST_DRAIN) ||
                       (state_q == ST_MIXED) || (state_q == ST_FLUSH);
    assign done      = (state_q == ST_DONE);
    assign enq_count = enq_cnt_q;
    assign deq_count = deq_cnt_q;
    assign wdata     = {(DATA_WIDTH / 16){enq_cnt_q}};

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        txn_d     = txn_q;
        enq_cnt_d = enq_cnt_q + {15'd0, enqueue};
        deq_cnt_d = deq_cnt_q + {15'd0, dequeue};
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_FILL;
                    lfsr_d    = SEED;
                    txn_d     = '0;
                    enq_cnt_d = 16'd0;
                    deq_cnt_d = 16'd0;
                end
            end
            ST_FILL:  if (is_full)  state_d = ST_DRAIN;
            ST_DRAIN: if (is_empty) state_d = ST_MIXED;
            ST_MIXED: begin
                lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
                txn_d  = txn_q + TXN_W'(1);
                if (txn_q == TXN_LAST) state_d = ST_FLUSH;
            end
            ST_FLUSH: if (is_empty) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= SEED;
            txn_q     <= '0;
            enq_cnt_q <= 16'd0;
            deq_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            txn_q     <= txn_d;
            enq_cnt_q <= enq_cnt_d;
            deq_cnt_q <= deq_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_stim_gen.sv
// tb/tb_fifo_stim_gen.sv - directed bench for fifo_stim_gen with a 16-deep FIFO occupancy model
module tb_fifo_stim_gen;
    localparam int P_IDLE = 0, P_FILL = 1, P_DRAIN = 2, P_MIXED = 3, P_FLUSH = 4, P_DONE = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_full, is_empty;
    logic        enqueue, dequeue, busy, done;
    logic [63:0] wdata;
    logic [15:0] enq_count, deq_count;

    logic use_model = 1'b0;
    logic man_full = 1'b0, man_empty = 1'b1;
    int   occ = 0;
    int   n_checks = 0, n_err = 0;

    always #5 clk = ~clk;

    fifo_stim_gen #(.DATA_WIDTH(64), .QUEUE_DEPTH(16), .NUM_TXN(256), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .is_full(is_full), .is_empty(is_empty),
        .enqueue(enqueue), .wdata(wdata), .dequeue(dequeue), .busy(busy), .done(done),
        .enq_count(enq_count), .deq_count(deq_count)
    );

    // Registered occupancy: flags follow one cycle after the causing edge, like a real FIFO.
    assign is_full  = use_model ? (occ >= 16) : man_full;
    assign is_empty = use_model ? (occ == 0)  : man_empty;
    always @(posedge clk) begin
        if (rst) occ <= 0;
        else if (use_model) occ <= occ + (enqueue ? 1 : 0) - (dequeue ? 1 : 0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic rst, start, full, empty;
        logic enq, deq, bsy, dn;
        logic [15:0] ec, dc;
    } vec_t;

    vec_t tbl[18];

    int          nenq, ndeq, fill_enq, drain_deq, ph, rt;
    logic [15:0] rl, re, rd;
    logic        e_enq, e_deq, e_busy, e_done, reached;
    logic [33:0] act_ctl, exp_ctl;

    initial begin
        //           rst   start full  empty enq   deq   busy  done  enq_cnt deq_cnt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 16'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 16'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 16'd2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd2};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd2};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3, 16'd2};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 16'd3};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 16'd4};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 16'd4};

        repeat (2) @(posedge clk);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst = tbl[i].rst;
            start = tbl[i].start;
            man_full = tbl[i].full;
            man_empty = tbl[i].empty;
            #1;
            chk($sformatf("row%0d_enqueue", i), enqueue, tbl[i].enq);
            chk($sformatf("row%0d_dequeue", i), dequeue, tbl[i].deq);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("row%0d_done", i), done, tbl[i].dn);
            chk($sformatf("row%0d_enq_count", i), enq_count, tbl[i].ec);
            chk($sformatf("row%0d_deq_count", i), deq_count, tbl[i].dc);
            chk($sformatf("row%0d_wdata", i), wdata, {4{tbl[i].ec}});
        end

        // Still in MIXED: flags held against the generator
        man_full = 1'b1; man_empty = 1'b0; nenq = 0; ndeq = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (enqueue) nenq++;
            if (dequeue) ndeq++;
        end
        chk("hold_full_no_enqueue", nenq, 0);
        chk("hold_full_dequeues_seen", ndeq > 0, 1);
        @(negedge clk);
        man_full = 1'b0; man_empty = 1'b1; nenq = 0; ndeq = 0;
        repeat (40) begin
            #1;
            if (enqueue) nenq++;
            if (dequeue) ndeq++;
            @(negedge clk);
        end
        chk("hold_empty_no_dequeue", ndeq, 0);
        chk("hold_empty_enqueues_seen", nenq > 0, 1);

        // Reset abandons a run in the middle of FILL
        use_model = 1'b1;
        do_reset();
        start = 1'b1;
        nenq = 0;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (enqueue) nenq++;
        end
        chk("midfill_enqueues", nenq, 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midfill_enq_count", enq_count, 5);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_ctl", {enqueue, dequeue, busy, done, enq_count, deq_count}, 34'd0);
        chk("after_rst_wdata", wdata, 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("restart_enqueue", enqueue, 1);
        chk("restart_wdata", wdata, 64'd0);

        // Full run against a phase-level reference, with a stray start pulse in MIXED
        do_reset();
        ph = P_IDLE; re = 16'd0; rd = 16'd0; rl = 16'hACE1; rt = 0;
        fill_enq = 0; drain_deq = 0; reached = 1'b0;
        for (int cyc = 0; cyc < 2000 && !reached; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (ph == P_MIXED && rt == 100);
            #1;
            e_enq = 1'b0;
            e_deq = 1'b0;
            case (ph)
                P_FILL:           e_enq = !is_full;
                P_DRAIN, P_FLUSH: e_deq = !is_empty;
                P_MIXED: begin
                    e_enq = rl[0] && !is_full;
                    e_deq = rl[1] && !is_empty;
                end
                default: ;
            endcase
            e_busy = (ph == P_FILL) || (ph == P_DRAIN) || (ph == P_MIXED) || (ph == P_FLUSH);
            e_done = (ph == P_DONE);
            act_ctl = {enqueue, dequeue, busy, done, enq_count, deq_count};
            exp_ctl = {e_enq, e_deq, e_busy, e_done, re, rd};
            chk($sformatf("run_c%0d_ctl", cyc), act_ctl, exp_ctl);
            if (e_enq) chk($sformatf("run_c%0d_wdata", cyc), wdata, {4{re}});
            if (ph == P_FILL && enqueue) fill_enq++;
            if (ph == P_DRAIN && dequeue) drain_deq++;
            re = re + {15'd0, e_enq};
            rd = rd + {15'd0, e_deq};
            case (ph)
                P_IDLE, P_DONE: if (start) begin
                    ph = P_FILL; re = 16'd0; rd = 16'd0; rl = 16'hACE1; rt = 0;
                end
                P_FILL:  if (is_full) ph = P_DRAIN;
                P_DRAIN: if (is_empty) ph = P_MIXED;
                P_MIXED: begin
                    if (rt == 255) ph = P_FLUSH;
                    rt++;
                    rl = rl[0] ? ((rl >> 1) ^ 16'hB400) : (rl >> 1);
                end
                P_FLUSH: if (is_empty) begin
                    ph = P_DONE;
                    reached = 1'b1;
                end
                default: ;
            endcase
        end
        chk("run_reached_done", reached, 1);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("final_done", done, 1);
        chk("final_busy", busy, 0);
        chk("final_counts_equal", enq_count, deq_count);
        chk("final_enq_count", enq_count, re);
        chk("final_fifo_empty", occ, 0);
        chk("fill_enqueues", fill_enq, 16);
        chk("drain_dequeues", drain_deq, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
